traffic_light_controller_nway: RTL

Parametrised N-approach intersection controller with per-approach vehicle sensors. It provides min/max green timing, fixed yellow and all-red clearance, and round-robin service that skips idle approaches. It adds emergency preemption and a night flash mode. It is the next generation of the two-street controller and sits between the sensor inputs and the per-approach lamp drivers.

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/rr_next_dir.sv | 34 +++
 rtl/traffic_light_controller_nway.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : traffic_pkg                                                  |
// | Description : Phase and lamp encodings shared by the intersection blocks.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package traffic_pkg;

    localparam logic [1:0] PH_GREEN  = 2'd0;
    localparam logic [1:0] PH_YELLOW = 2'd1;
    localparam logic [1:0] PH_ALLRED = 2'd2;
    localparam logic [1:0] PH_FLASH  = 2'd3;

    typedef enum logic [1:0] {
        LAMP_R = 2'd0,
        LAMP_Y = 2'd1,
        LAMP_G = 2'd2
    } lamp_e;

endpackage
`default_nettype wire

// File: rtl/rr_next_dir.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_next_dir                                                  |
// | Description : Finds the first requesting approach after the current one.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module rr_next_dir #(
    parameter  int N_DIR = 4,
    localparam int DW    = $clog2(N_DIR)
) (
    input  logic [N_DIR-1:0] i_req,
    input  logic [DW-1:0]    i_cur,
    output logic             o_found,
    output logic [DW-1:0]    o_next
);

    logic [DW-1:0] w_idx;

    // Scan farthest-first so the nearest requester overwrites and wins.
    always_comb begin
        o_found = 1'b0;
        o_next  = i_cur;
        w_idx   = '0;
        for (int k = N_DIR - 1; k >= 1; k--) begin
            w_idx = DW'((int'(i_cur) + k) % N_DIR);
            if (i_req[w_idx]) begin
                o_found = 1'b1;
                o_next  = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_controller_nway.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : traffic_light_controller_nway                                |
// | Description : N-approach controller: sensors, preemption, night flash.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module traffic_light_controller_nway
    import traffic_pkg::*;
#(
    parameter  int N_DIR      = 4,
    parameter  int CNT_W      = 8,
    parameter  int MIN_GREEN  = 5,
    parameter  int MAX_GREEN  = 20,
    parameter  int YELLOW     = 2,
    parameter  int ALL_RED    = 1,
    parameter  int FLASH_HALF = 4,
    localparam int DW         = $clog2(N_DIR)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_DIR-1:0] sensor,
    input  logic             preempt_valid,
    input  logic [DW-1:0]    preempt_dir,
    input  logic             flash_mode,
    output logic [N_DIR-1:0] red,
    output logic [N_DIR-1:0] yellow,
    output logic [N_DIR-1:0] green,
    output logic [DW-1:0]    active_dir,
    output logic [1:0]       phase
);

    if (N_DIR < 2 || N_DIR > 8 || MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN ||
        YELLOW < 1 || ALL_RED < 1 || FLASH_HALF < 1 || CNT_W < 1) begin : g_param_check
        $error("traffic_light_controller_nway: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] c_min_m1   = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] c_max_m1   = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] c_yel_m1   = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] c_ar_m1    = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] c_flash_m1 = CNT_W'(FLASH_HALF - 1);
    localparam logic [DW:0]      c_n_dir    = (DW + 1)'(N_DIR);

    logic [1:0]       r_phase, w_phase_nx;
    logic [DW-1:0]    r_active_dir, w_active_nx;
    logic [DW-1:0]    r_next_dir, w_next_nx;
    logic [CNT_W-1:0] r_timer;
    logic             w_timer_clr;
    logic             r_flash_off, w_flash_off_nx;

    logic             w_pv;
    logic [N_DIR-1:0] w_active_oh;
    logic             w_others_req;
    logic             w_rr_found;
    logic [DW-1:0]    w_rr_dir;

    // An out-of-range target is treated as no request at all.
    assign w_pv         = preempt_valid && ({1'b0, preempt_dir} < c_n_dir);
    assign w_active_oh  = N_DIR'(1) << r_active_dir;
    assign w_others_req = |(sensor & ~w_active_oh);

    rr_next_dir #(
        .N_DIR (N_DIR)
    ) u_rr (
        .i_req   (sensor),
        .i_cur   (r_active_dir),
        .o_found (w_rr_found),
        .o_next  (w_rr_dir)
    );

    always_comb begin
        w_phase_nx     = r_phase;
        w_active_nx    = r_active_dir;
        w_next_nx      = r_next_dir;
        w_flash_off_nx = r_flash_off;
        w_timer_clr    = 1'b0;
        case (r_phase)
            PH_GREEN: begin
                if (w_pv && preempt_dir == r_active_dir) begin
                    w_phase_nx = PH_GREEN;
                end else if (w_pv) begin
                    w_phase_nx = PH_YELLOW;
                    w_next_nx  = preempt_dir;
                end else if (flash_mode) begin
                    w_phase_nx = PH_YELLOW;
                    w_next_nx  = r_active_dir;
                end else if (r_timer >= c_min_m1 && w_others_req && w_rr_found &&
                             (!sensor[r_active_dir] || r_timer >= c_max_m1)) begin
                    w_phase_nx = PH_YELLOW;
                    w_next_nx  = w_rr_dir;
                end
            end
            PH_YELLOW: begin
                if (w_pv) begin
                    w_next_nx = preempt_dir;
                end
                if (r_timer >= c_yel_m1) begin
                    w_phase_nx = PH_ALLRED;
                end
            end
            PH_ALLRED: begin
                if (r_timer >= c_ar_m1) begin
                    if (w_pv) begin
                        w_phase_nx  = PH_GREEN;
                        w_active_nx = preempt_dir;
                        w_next_nx   = preempt_dir;
                    end else if (flash_mode) begin
                        w_phase_nx     = PH_FLASH;
                        w_flash_off_nx = 1'b0;
                    end else begin
                        w_phase_nx  = PH_GREEN;
                        w_active_nx = r_next_dir;
                    end
                end
            end
            PH_FLASH: begin
                if (w_pv || !flash_mode) begin
                    w_phase_nx = PH_ALLRED;
                    w_next_nx  = w_pv ? preempt_dir : '0;
                end else if (r_timer >= c_flash_m1) begin
                    // The phase timer doubles as the flash half-period counter.
                    w_flash_off_nx = !r_flash_off;
                    w_timer_clr    = 1'b1;
                end
            end
            default: begin
                w_phase_nx  = PH_GREEN;
                w_active_nx = '0;
            end
        endcase
        if (w_phase_nx != r_phase) begin
            w_timer_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase      <= PH_GREEN;
            r_active_dir <= '0;
            r_next_dir   <= '0;
            r_timer      <= '0;
            r_flash_off  <= 1'b0;
        end else begin
            r_phase      <= w_phase_nx;
            r_active_dir <= w_active_nx;
            r_next_dir   <= w_next_nx;
            r_flash_off  <= w_flash_off_nx;
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (r_timer != {CNT_W{1'b1}}) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N_DIR; gi++) begin : g_lamp
        lamp_e w_lamp;

        always_comb begin
            w_lamp = LAMP_R;
            if (r_active_dir == DW'(gi)) begin
                if (r_phase == PH_GREEN) begin
                    w_lamp = LAMP_G;
                end else if (r_phase == PH_YELLOW) begin
                    w_lamp = LAMP_Y;
                end
            end
        end

        assign red[gi]    = (r_phase == PH_FLASH) ? !r_flash_off : (w_lamp == LAMP_R);
        assign yellow[gi] = (w_lamp == LAMP_Y);
        assign green[gi]  = (w_lamp == LAMP_G);
    end

    assign active_dir = r_active_dir;
    assign phase      = r_phase;

endmodule
`default_nettype wire
